// File: rtl/lcd_msg_sequencer.sv
// LCD message sequencer: waits out LCD power-up, sends the HD44780 init list,
// then writes a latched 32-character two-line frame to the character driver,
// one byte per driver handshake, re-sending on each accepted message request.
module lcd_msg_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 405000,
  parameter int unsigned ACK_TIMEOUT    = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] msg_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  output logic [7:0]   lcd_data,
  output logic         lcd_select_cd,
  output logic         lcd_enable_writing,
  input  logic         lcd_available,
  output logic         init_done,
  output logic         busy,
  output logic         error
);

  typedef enum logic [1:0] {PWRUP, INIT, IDLE, SEND} phase_t;
  typedef enum logic [1:0] {ISSUE, WAIT_BUSY, WAIT_DONE} hs_t;

  localparam logic [18:0] PWR_LAST = 19'(POWERUP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  phase_t      r_phase;
  hs_t         r_hs;
  logic [18:0] r_pwr_cnt;
  logic [15:0] r_tmo_cnt;
  logic [5:0]  r_idx;
  logic [7:0]  r_buf [32];

  logic [7:0]  w_byte;
  logic        w_cd;
  logic [4:0]  w_char;
  logic        w_tmo_hit;
  logic        w_done;
  logic        w_timeout;
  logic        w_last;

  // Byte/select for the current list index, and handshake completion decode.
  always_comb begin
    w_byte = '0;
    w_cd   = 1'b0;
    w_char = '0;
    if (r_phase == INIT) begin
      case (r_idx[1:0])
        2'd0:    w_byte = 8'h38;
        2'd1:    w_byte = 8'h0C;
        2'd2:    w_byte = 8'h01;
        default: w_byte = 8'h06;
      endcase
    end else if (r_idx == 6'd0) begin
      w_byte = 8'h80;
    end else if (r_idx == 6'd17) begin
      w_byte = 8'hC0;
    end else begin
      w_cd   = 1'b1;
      w_char = (r_idx < 6'd17) ? 5'(r_idx - 6'd1) : 5'(r_idx - 6'd2);
      w_byte = r_buf[w_char];
    end
    w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    w_timeout = ((r_hs == WAIT_BUSY) &&  lcd_available && w_tmo_hit) ||
                ((r_hs == WAIT_DONE) && !lcd_available && w_tmo_hit);
    w_done    = w_timeout || ((r_hs == WAIT_DONE) && lcd_available);
    w_last    = (r_phase == INIT) ? (r_idx == 6'd3) : (r_idx == 6'd33);
  end

  // Top-level sequencing, write handshake and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase            <= PWRUP;
      r_hs               <= ISSUE;
      r_pwr_cnt          <= '0;
      r_tmo_cnt          <= '0;
      r_idx              <= '0;
      lcd_data           <= '0;
      lcd_select_cd      <= 1'b0;
      lcd_enable_writing <= 1'b0;
      msg_ready          <= 1'b0;
      init_done          <= 1'b0;
      busy               <= 1'b1;
      error              <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else begin
      lcd_enable_writing <= 1'b0;
      case (r_phase)
        PWRUP: begin
          if (r_pwr_cnt == PWR_LAST) begin
            r_phase   <= INIT;
            r_hs      <= ISSUE;
            r_idx     <= '0;
            r_tmo_cnt <= '0;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 19'd1;
          end
        end
        IDLE: begin
          if (msg_valid) begin
            for (int unsigned i = 0; i < 32; i++) r_buf[i] <= msg_data[255-8*i -: 8];
            r_phase   <= SEND;
            r_hs      <= ISSUE;
            r_idx     <= '0;
            msg_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        default: begin
          case (r_hs)
            ISSUE: begin
              if (lcd_available) begin
                lcd_data           <= w_byte;
                lcd_select_cd      <= w_cd;
                lcd_enable_writing <= 1'b1;
                r_hs               <= WAIT_BUSY;
                r_tmo_cnt          <= '0;
              end
            end
            WAIT_BUSY: begin
              if (!lcd_available) begin
                r_hs      <= WAIT_DONE;
                r_tmo_cnt <= '0;
              end else if (!w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
              end
            end
            default: begin
              if (!lcd_available && !w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
          endcase
          if (w_timeout) error <= 1'b1;
          // A timed-out write still counts as complete, so completion overrides
          // the per-state handshake updates above.
          if (w_done) begin
            r_hs <= ISSUE;
            if (w_last) begin
              r_idx <= '0;
              if (r_phase == INIT) begin
                r_phase   <= SEND;
                init_done <= 1'b1;
                for (int unsigned i = 0; i < 32; i++) r_buf[i] <= 8'h20;
              end else begin
                r_phase   <= IDLE;
                msg_ready <= 1'b1;
                busy      <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed bench for lcd_msg_sequencer with a simple LCD driver model.
module tb_lcd_msg_sequencer;

  localparam int PW       = 50;
  localparam int AT       = 48;
  localparam int BUSY_LEN = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] msg_data = '0;
  logic         msg_valid = 1'b0;
  logic         lcd_available = 1'b1;
  logic         msg_ready, lcd_select_cd, lcd_enable_writing, init_done, busy, error;
  logic [7:0]   lcd_data;

  lcd_msg_sequencer #(.POWERUP_CYCLES(PW), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .lcd_data(lcd_data), .lcd_select_cd(lcd_select_cd),
    .lcd_enable_writing(lcd_enable_writing), .lcd_available(lcd_available),
    .init_done(init_done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drv_mode = 0;  // 0 normal driver, 1 never busy, 2 held unavailable
  logic pend = 1'b0;
  int bcnt = 0;
  logic [8:0] log_q[$];
  int         log_t[$];

  always @(posedge clk) cyc++;

  // Strobe logger: {select_cd, data} and cycle of each write strobe.
  always @(negedge clk) begin
    if (lcd_enable_writing) begin
      log_q.push_back({lcd_select_cd, lcd_data});
      log_t.push_back(cyc);
    end
  end

  // Driver model: goes busy one cycle after a strobe, idle BUSY_LEN cycles later.
  always @(negedge clk) begin
    case (drv_mode)
      2: begin lcd_available = 1'b0; pend = 1'b0; bcnt = 0; end
      1: begin lcd_available = 1'b1; pend = 1'b0; bcnt = 0; end
      default: begin
        if (pend) begin
          lcd_available = 1'b0; bcnt = BUSY_LEN; pend = 1'b0;
        end else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) lcd_available = 1'b1;
        end else begin
          lcd_available = 1'b1;
        end
        if (lcd_enable_writing) pend = 1'b1;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_frame(input logic [255:0] m, input int k);
    if (k == 0)  return 9'h080;
    if (k == 17) return 9'h0C0;
    if (k < 17)  return {1'b1, m[255-8*(k-1) -: 8]};
    return {1'b1, m[255-8*(k-2) -: 8]};
  endfunction

  function automatic logic [8:0] exp_init(input int k);
    case (k)
      0:       return 9'h038;
      1:       return 9'h00C;
      2:       return 9'h001;
      default: return 9'h006;
    endcase
  endfunction

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk(tag, 32'(log_q.size() >= n), 1);
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int k = 0;
    while (!msg_ready && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk(tag, 32'(msg_ready), 1);
  endtask

  task automatic check_frame(input int base, input logic [255:0] m, input string tag);
    for (int k = 0; k < 34; k++)
      chk($sformatf("%s[%0d]", tag, k), 32'(log_q[base+k]), 32'(exp_frame(m, k)));
  endtask

  task automatic check_init(input string tag);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s[%0d]", tag, k), 32'(log_q[k]), 32'(exp_init(k)));
  endtask

  task automatic clear_log();
    log_q.delete();
    log_t.delete();
  endtask

  task automatic send_msg(input logic [255:0] m, input string tag);
    @(negedge clk);
    msg_data  = m;
    msg_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ready_drop"}, 32'(msg_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  task automatic powerup_and_init(input string tag);
    logic [255:0] spaces;
    int n = 0;
    spaces = {32{8'h20}};
    while (!lcd_enable_writing && n < PW + 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_pwrup_delay"}, 32'(n), 32'(PW + 1));
    wait_log(4, 1000, {tag, "_init_wait"});
    chk({tag, "_init_done_at_last_cmd"}, 32'(init_done), 0);
    check_init({tag, "_init"});
    wait_log(38, 5000, {tag, "_blank_wait"});
    chk({tag, "_init_done"}, 32'(init_done), 1);
    check_frame(4, spaces, {tag, "_blank"});
    wait_ready(1000, {tag, "_ready"});
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic [255:0] ma, mb, mc, md;
    ma = "HELLO WORLD     LINE TWO        ";
    mb = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
    mc = "zyxwvutsrqponmlkjihgfedcba987654";
    md = "Timeout test    sticky error 1! ";

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe", 32'(lcd_enable_writing), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ready", 32'(msg_ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_data", 32'(lcd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    powerup_and_init("boot");

    // Normal message
    clear_log();
    send_msg(ma, "hello");
    wait_log(34, 5000, "hello_wait");
    check_frame(0, ma, "hello");
    wait_ready(1000, "hello_ready");
    repeat (20) @(posedge clk);
    #1;
    chk("hello_count", 32'(log_q.size()), 34);

    // New request mid-frame is ignored until IDLE, then accepted
    clear_log();
    send_msg(mb, "latch");
    wait_log(10, 5000, "latch_mid");
    @(negedge clk);
    msg_data  = mc;
    msg_valid = 1'b1;
    wait_log(34, 5000, "latch_wait");
    chk("latch_ready_in_send", 32'(msg_ready), 0);
    check_frame(0, mb, "latch");
    wait_ready(1000, "latch_ready");
    @(posedge clk); #1;
    chk("held_req_accept", 32'(msg_ready), 0);
    msg_valid = 1'b0;
    wait_log(68, 5000, "second_wait");
    check_frame(34, mc, "second");
    wait_ready(1000, "second_ready");

    // Driver never goes busy: timeout path
    clear_log();
    chk("err_clear", 32'(error), 0);
    @(posedge clk); #2;
    drv_mode = 1;
    send_msg(md, "tmo");
    wait_log(1, 1000, "tmo_first");
    chk("err_before_tmo", 32'(error), 0);
    wait_log(2, 1000, "tmo_second");
    chk("err_after_tmo", 32'(error), 1);
    chk("tmo_gap", 32'(log_t[1] - log_t[0]), 32'(AT + 1));
    wait_log(34, 34 * (AT + 10), "tmo_wait");
    check_frame(0, md, "tmo");
    wait_ready(1000, "tmo_ready");
    chk("err_sticky", 32'(error), 1);
    @(posedge clk); #2;
    drv_mode = 0;
    repeat (5) @(posedge clk);

    // Available held low at ISSUE
    clear_log();
    @(posedge clk); #2;
    drv_mode = 2;
    send_msg(ma, "hold");
    repeat (100) @(posedge clk);
    #1;
    chk("hold_no_strobe", 32'(log_q.size()), 0);
    chk("hold_strobe_low", 32'(lcd_enable_writing), 0);
    @(posedge clk); #2;
    drv_mode = 0;
    @(negedge clk); #1;
    chk("hold_avail_up", 32'(lcd_available), 1);
    chk("hold_strobe_same_cycle", 32'(lcd_enable_writing), 0);
    @(posedge clk); #1;
    chk("hold_strobe_next", 32'(lcd_enable_writing), 1);
    wait_log(34, 5000, "hold_wait");
    check_frame(0, ma, "hold");
    wait_ready(1000, "hold_ready");
    chk("err_still_sticky", 32'(error), 1);

    // Reset during char 10 of a frame
    clear_log();
    send_msg(mb, "abort");
    wait_log(12, 5000, "abort_char10");
    chk("abort_char10_byte", 32'(log_q[11]), 32'({1'b1, 8'h4B}));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_strobe", 32'(lcd_enable_writing), 0);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_init_done", 32'(init_done), 0);
    chk("abort_ready", 32'(msg_ready), 0);
    chk("abort_error", 32'(error), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    powerup_and_init("reboot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
